// File: rtl/mem_line_xfer.sv
// mem_line_xfer: cache line engine doing an optional victim writeback burst, then a fill burst.
module mem_line_xfer #(
    parameter int BURST_WIDTH = 8,
    parameter int OFFSET_BITS = $clog2(BURST_WIDTH)
) (
    input  logic                     MEM_CLK,
    input  logic                     RST,
    input  logic                     REQ,
    input  logic                     WB_EN,
    input  logic [29-OFFSET_BITS:0]  WB_LINE,
    input  logic [32*BURST_WIDTH-1:0] WB_DATA,
    input  logic [29-OFFSET_BITS:0]  FILL_LINE,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [32*BURST_WIDTH-1:0] FILL_DATA,
    output logic                     MEM_RE,
    output logic                     MEM_WE,
    output logic [29:0]              MEM_ADDR,
    output logic [31:0]              MEM_DATA_IN,
    input  logic [31:0]              MEM_DOUT,
    input  logic                     memValid
);
    typedef enum logic [2:0] {S_IDLE, S_WB, S_GAP, S_FILL, S_DONE} state_t;
    state_t state;
    logic [29-OFFSET_BITS:0] wb_line, fill_line;
    logic [32*BURST_WIDTH-1:0] wb_data;
    logic [OFFSET_BITS-1:0] beat, nxt;
    logic last;
    assign nxt = beat + 1'b1;
    assign last = &beat;
    always_ff @(posedge MEM_CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            MEM_RE      <= 1'b0;
            MEM_WE      <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_DATA_IN <= '0;
            FILL_DATA   <= '0;
            beat        <= '0;
            wb_line     <= '0;
            fill_line   <= '0;
            wb_data     <= '0;
        end else begin
            case (state)
                S_IDLE: if (REQ) begin
                    wb_line     <= WB_LINE;
                    fill_line   <= FILL_LINE;
                    wb_data     <= WB_DATA;
                    BUSY        <= 1'b1;
                    MEM_WE      <= WB_EN;
                    MEM_RE      <= !WB_EN;
                    MEM_ADDR    <= {WB_EN ? WB_LINE : FILL_LINE, {OFFSET_BITS{1'b0}}};
                    MEM_DATA_IN <= WB_EN ? WB_DATA[31:0] : 32'd0;
                    state       <= WB_EN ? S_WB : S_FILL;
                end
                // address and data step on the edge that consumes a beat
                S_WB: if (memValid) begin
                    beat <= nxt;
                    if (last) begin
                        MEM_WE      <= 1'b0;
                        MEM_DATA_IN <= '0;
                        state       <= S_GAP;
                    end else begin
                        MEM_ADDR    <= {wb_line, nxt};
                        MEM_DATA_IN <= wb_data[{nxt, 5'd0} +: 32];
                    end
                end
                S_GAP: begin
                    MEM_RE   <= 1'b1;
                    MEM_ADDR <= {fill_line, {OFFSET_BITS{1'b0}}};
                    state    <= S_FILL;
                end
                S_FILL: if (memValid) begin
                    FILL_DATA[{beat, 5'd0} +: 32] <= MEM_DOUT;
                    beat <= nxt;
                    if (last) begin
                        MEM_RE <= 1'b0;
                        DONE   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        MEM_ADDR <= {fill_line, nxt};
                    end
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_xfer.sv
// tb_mem_line_xfer: table-driven line transfers against a delayed burst memory model.
module tb_mem_line_xfer;
    localparam int BW = 8, OB = 3, LW = 30 - OB, DELAY = 10;

    logic MEM_CLK = 0, RST = 0, REQ = 0, WB_EN = 0;
    logic [LW-1:0] WB_LINE = '0, FILL_LINE = '0;
    logic [32*BW-1:0] WB_DATA = '0;
    logic BUSY, DONE, MEM_RE, MEM_WE;
    logic memValid = 0;
    logic [32*BW-1:0] FILL_DATA;
    logic [29:0] MEM_ADDR;
    logic [31:0] MEM_DATA_IN;
    logic [31:0] MEM_DOUT = 0;

    mem_line_xfer #(.BURST_WIDTH(BW)) dut (
        .MEM_CLK(MEM_CLK), .RST(RST), .REQ(REQ), .WB_EN(WB_EN), .WB_LINE(WB_LINE),
        .WB_DATA(WB_DATA), .FILL_LINE(FILL_LINE), .BUSY(BUSY), .DONE(DONE),
        .FILL_DATA(FILL_DATA), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA_IN(MEM_DATA_IN), .MEM_DOUT(MEM_DOUT), .memValid(memValid)
    );

    always #5 MEM_CLK = ~MEM_CLK;

    // memory: word k holds k, DELAY enabled cycles before beats, optional stall pattern
    logic [31:0] mem [0:255];
    bit inited = 0, stall = 0;
    logic [6:0] pat = 7'b1011001;
    int pi = 0, dly = 0, done_cnt = 0, gap_cnt = 0, both_cnt = 0, wr_cnt = 0, en_cnt = 0;
    logic [29:0] rd_addr [$];
    wire beat_ok = !stall || pat[3'(pi % 7)];

    always @(negedge MEM_CLK) begin
        if (!inited) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'(k);
            inited <= 1;
        end
        if (MEM_RE || MEM_WE) begin
            en_cnt <= en_cnt + 1;
            if (dly < DELAY) begin
                dly <= dly + 1;
                memValid <= 0;
            end else begin
                pi <= pi + 1;
                memValid <= beat_ok;
                if (beat_ok && MEM_WE) begin
                    mem[MEM_ADDR[7:0]] <= MEM_DATA_IN;
                    wr_cnt <= wr_cnt + 1;
                end
                if (beat_ok && MEM_RE) begin
                    MEM_DOUT <= mem[MEM_ADDR[7:0]];
                    rd_addr.push_back(MEM_ADDR);
                end
            end
        end else begin
            dly <= 0;
            memValid <= 0;
        end
        done_cnt <= done_cnt + int'(DONE);
        gap_cnt  <= gap_cnt + int'(BUSY && !DONE && !MEM_RE && !MEM_WE);
        both_cnt <= both_cnt + int'(MEM_RE && MEM_WE);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_req(bit wb, logic [LW-1:0] wl, logic [31:0] wbase, logic [LW-1:0] fl);
        @(negedge MEM_CLK);
        WB_EN = wb;
        WB_LINE = wl;
        FILL_LINE = fl;
        for (int i = 0; i < BW; i++) WB_DATA[32*i +: 32] = wbase + 32'(i);
        REQ = 1;
        @(negedge MEM_CLK);
        REQ = 0;
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        while (!DONE && n < 400) begin
            @(negedge MEM_CLK);
            n++;
        end
        chk({nm, "_done_seen"}, 64'(DONE), 1);
    endtask

    typedef struct {
        bit            wb;
        logic [LW-1:0] wl;
        logic [31:0]   wbase;
        logic [LW-1:0] fl;
        bit            st;
        logic [31:0]   exp0;
    } vec_t;
    vec_t vt [5];
    int d0, g0, b0, w0, r0, e0, n;

    initial begin
        vt[0] = '{1'b0, 27'd0, 32'h0,        27'd5, 1'b0, 32'd40};
        vt[1] = '{1'b1, 27'd2, 32'hA0000000, 27'd3, 1'b0, 32'd24};
        vt[2] = '{1'b0, 27'd0, 32'h0,        27'd7, 1'b1, 32'd56};
        vt[3] = '{1'b1, 27'd6, 32'hB0000000, 27'd6, 1'b1, 32'hB0000000};
        vt[4] = '{1'b1, 27'd9, 32'hC0000000, 27'd0, 1'b0, 32'd0};

        repeat (3) @(negedge MEM_CLK);
        chk("rst_ctrl", {MEM_RE, MEM_WE, BUSY, DONE, MEM_ADDR, MEM_DATA_IN}, 0);
        chk("rst_fill_zero", 64'(FILL_DATA == '0), 1);
        RST = 1;
        @(negedge MEM_CLK);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt; g0 = gap_cnt; b0 = both_cnt; w0 = wr_cnt; r0 = rd_addr.size();
            stall = vt[v].st;
            start_req(vt[v].wb, vt[v].wl, vt[v].wbase, vt[v].fl);
            chk("first_cycle", {BUSY, MEM_WE, MEM_RE}, {1'b1, vt[v].wb, !vt[v].wb});
            wait_done("vec");
            chk("busy_in_done", 64'(BUSY), 1);
            for (int i = 0; i < BW; i++)
                chk("fill_word", FILL_DATA[32*i +: 32], vt[v].exp0 + 32'(i));
            @(negedge MEM_CLK);
            chk("busy_after", 64'(BUSY), 0);
            @(negedge MEM_CLK);
            chk("done_pulses", done_cnt - d0, 1);
            chk("gap_cycles", gap_cnt - g0, 64'(vt[v].wb));
            chk("both_enables", both_cnt - b0, 0);
            chk("write_beats", wr_cnt - w0, vt[v].wb ? 8 : 0);
            chk("read_beats", rd_addr.size() - r0, 8);
            for (int i = 0; i < BW; i++)
                chk("read_addr", rd_addr[r0 + i], {vt[v].fl, 3'(i)});
            if (vt[v].wb)
                for (int i = 0; i < BW; i++)
                    chk("wb_mem", mem[8 * int'(vt[v].wl) + i], vt[v].wbase + 32'(i));
        end

        // second request during a fill must be dropped
        stall = 0;
        d0 = done_cnt; r0 = rd_addr.size();
        start_req(0, 0, 0, 5);
        repeat (4) @(negedge MEM_CLK);
        FILL_LINE = 9;
        REQ = 1;
        @(negedge MEM_CLK);
        REQ = 0;
        wait_done("busy_req");
        chk("busy_req_w0", FILL_DATA[31:0], 40);
        chk("busy_req_w7", FILL_DATA[255:224], 47);
        repeat (2) @(negedge MEM_CLK);
        e0 = en_cnt;
        repeat (30) @(negedge MEM_CLK);
        chk("busy_req_no_second", en_cnt - e0, 0);
        chk("busy_req_done", done_cnt - d0, 1);
        chk("busy_req_reads", rd_addr.size() - r0, 8);
        chk("busy_req_idle", 64'(BUSY), 0);

        // reset in the middle of a writeback burst
        d0 = done_cnt; w0 = wr_cnt;
        start_req(1, 4, 32'hD0000000, 1);
        n = 0;
        while ((wr_cnt - w0) < 3 && n < 200) begin
            @(negedge MEM_CLK);
            #1;
            n++;
        end
        chk("rst_wb_beats", wr_cnt - w0, 3);
        RST = 0;
        @(negedge MEM_CLK);
        chk("rst_wb_ctrl", {MEM_RE, MEM_WE, BUSY, DONE, MEM_ADDR, MEM_DATA_IN}, 0);
        chk("rst_wb_fill_zero", 64'(FILL_DATA == '0), 1);
        RST = 1;
        repeat (20) @(negedge MEM_CLK);
        chk("rst_wb_no_done", done_cnt - d0, 0);
        start_req(0, 0, 0, 8);
        chk("rst_after_first", {BUSY, MEM_WE, MEM_RE}, 3'b101);
        wait_done("rst_after");
        chk("rst_after_w0", FILL_DATA[31:0], 64);
        chk("rst_after_w7", FILL_DATA[255:224], 71);

        // REQ held high across DONE restarts only from IDLE
        repeat (2) @(negedge MEM_CLK);
        d0 = done_cnt;
        WB_EN = 0;
        FILL_LINE = 1;
        REQ = 1;
        @(negedge MEM_CLK);
        wait_done("b2b1");
        chk("b2b_done_enables", {MEM_RE, MEM_WE}, 0);
        @(negedge MEM_CLK);
        chk("b2b_idle", {BUSY, MEM_RE}, 0);
        @(negedge MEM_CLK);
        chk("b2b_restart", {BUSY, MEM_RE}, 2'b11);
        REQ = 0;
        wait_done("b2b2");
        chk("b2b_w0", FILL_DATA[31:0], 8);
        repeat (2) @(negedge MEM_CLK);
        chk("b2b_done_count", done_cnt - d0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
